// File: rtl/bpsk_mapper_if.sv
// Handshake and sample bus between a bit/carrier source and the BPSK mapper.
interface bpsk_mapper_if;
  logic signed [15:0] carrier_sig;
  logic               bit_in;
  logic               bit_valid;
  logic               bit_ready;
  logic signed [15:0] mod_sig;
  logic               mod_valid;
  logic               sym_strobe;
  logic               underrun;

  modport master (
    output carrier_sig, bit_in, bit_valid,
    input  bit_ready, mod_sig, mod_valid, sym_strobe, underrun
  );

  modport slave (
    input  carrier_sig, bit_in, bit_valid,
    output bit_ready, mod_sig, mod_valid, sym_strobe, underrun
  );
endinterface

// File: rtl/bpsk_mapper.sv
// BPSK mapper: holds each data bit for one carrier-locked symbol period and
// emits the carrier as-is (bit 0) or negated with saturation (bit 1).
module bpsk_mapper #(
  parameter int unsigned SAMPLES_PER_SYM = 256,
  parameter int unsigned ALIGN_OFFSET    = 2,
  parameter bit          DIFF_EN         = 1'b0
) (
  input  logic         clk_sig,
  input  logic         rst_n,
  bpsk_mapper_if.slave bus
);
  localparam int unsigned CW = (SAMPLES_PER_SYM > 1) ? $clog2(SAMPLES_PER_SYM) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_phase_cnt;
  logic               r_buf_full;
  logic               r_buf_bit;
  logic               r_cur_sym;
  logic               r_prev_sym;
  logic signed [15:0] r_mod_sig;
  logic               r_mod_valid;
  logic               r_sym_strobe;
  logic               r_underrun;

  logic               w_boundary;
  logic               w_ready;
  logic               w_accept;
  logic               w_load;
  logic               w_sym_new;
  logic               w_run_nxt;
  logic               w_sym_nxt;
  logic signed [15:0] w_neg;

  assign w_boundary = (r_phase_cnt == CW'(ALIGN_OFFSET));
  assign w_ready    = rst_n & (~r_buf_full | w_boundary);
  assign w_accept   = bus.bit_valid & w_ready;
  assign w_load     = w_boundary & r_buf_full;
  assign w_sym_new  = DIFF_EN ? (r_prev_sym ^ r_buf_bit) : r_buf_bit;

  // Output register looks at the post-edge state so the first sample of a
  // new symbol lands on the cycle after the boundary, with sym_strobe.
  assign w_run_nxt  = w_load | ((r_state == RUN) & ~w_boundary);
  assign w_sym_nxt  = w_load ? w_sym_new : r_cur_sym;
  assign w_neg      = (bus.carrier_sig == 16'sh8000) ? 16'sh7FFF : -bus.carrier_sig;

  always_ff @(posedge clk_sig) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_phase_cnt  <= '0;
      r_buf_full   <= 1'b0;
      r_buf_bit    <= 1'b0;
      r_cur_sym    <= 1'b0;
      r_prev_sym   <= 1'b0;
      r_mod_sig    <= '0;
      r_mod_valid  <= 1'b0;
      r_sym_strobe <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_phase_cnt <= (r_phase_cnt == CW'(SAMPLES_PER_SYM - 1)) ? '0 : r_phase_cnt + 1'b1;

      // An accept on a boundary replaces the bit being consumed.
      if (w_accept) begin
        r_buf_full <= 1'b1;
        r_buf_bit  <= bus.bit_in;
      end else if (w_load) begin
        r_buf_full <= 1'b0;
      end

      if (w_load) begin
        r_state   <= RUN;
        r_cur_sym <= w_sym_new;
        if (DIFF_EN) r_prev_sym <= w_sym_new;
      end else if (w_boundary && (r_state == RUN)) begin
        r_state    <= IDLE;
        r_underrun <= 1'b1;
      end

      r_sym_strobe <= w_load;
      r_mod_valid  <= w_run_nxt;
      r_mod_sig    <= !w_run_nxt ? '0 : (w_sym_nxt ? w_neg : bus.carrier_sig);
    end
  end

  assign bus.bit_ready  = w_ready;
  assign bus.mod_sig    = r_mod_sig;
  assign bus.mod_valid  = r_mod_valid;
  assign bus.sym_strobe = r_sym_strobe;
  assign bus.underrun   = r_underrun;
endmodule

// File: tb/tb_bpsk_mapper.sv
// Bench for bpsk_mapper: direct and differential instances share stimulus and
// are compared every cycle against a queue-based symbol model.
module tb_bpsk_mapper;
  localparam int unsigned SPS = 256;
  localparam int unsigned AO  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic signed [15:0] carrier = '0;
  logic               bit_in = 1'b0;
  logic               bit_valid = 1'b0;

  bpsk_mapper_if bus0 ();
  bpsk_mapper_if bus1 ();

  assign bus0.carrier_sig = carrier;
  assign bus0.bit_in      = bit_in;
  assign bus0.bit_valid   = bit_valid;
  assign bus1.carrier_sig = carrier;
  assign bus1.bit_in      = bit_in;
  assign bus1.bit_valid   = bit_valid;

  bpsk_mapper #(.SAMPLES_PER_SYM(SPS), .ALIGN_OFFSET(AO), .DIFF_EN(1'b0)) u_dut0 (
    .clk_sig(clk), .rst_n(rst_n), .bus(bus0)
  );
  bpsk_mapper #(.SAMPLES_PER_SYM(SPS), .ALIGN_OFFSET(AO), .DIFF_EN(1'b1)) u_dut1 (
    .clk_sig(clk), .rst_n(rst_n), .bus(bus1)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Bits waiting to be offered, and the model's view of the one-deep buffer.
  bit tx_q[$];
  bit mq[$];
  bit rand_car = 1'b0;

  int unsigned        m_n = 0;
  bit                 m_run = 1'b0, m_strb = 1'b0, m_und = 1'b0;
  bit                 m_sym [2];
  bit                 m_prev[2];
  logic signed [15:0] m_out [2];

  function automatic logic signed [15:0] neg_sat(input logic signed [15:0] x);
    int v;
    v = -int'(x);
    if (v > 32767) v = 32767;
    return 16'(v);
  endfunction

  function automatic logic [19:0] exp_vec(input int i);
    logic rdy;
    rdy = rst_n && ((mq.size() == 0) || ((m_n % SPS) == AO));
    return {m_out[i], m_run, m_strb, m_und, rdy};
  endfunction

  function automatic logic [19:0] obs_vec(input int i);
    if (i == 0) return {bus0.mod_sig, bus0.mod_valid, bus0.sym_strobe, bus0.underrun, bus0.bit_ready};
    return {bus1.mod_sig, bus1.mod_valid, bus1.sym_strobe, bus1.underrun, bus1.bit_ready};
  endfunction

  // Drive one cycle of stimulus and advance the model across the clock edge.
  task automatic step();
    bit bnd, acc, b;
    logic signed [15:0] c;
    if (rand_car) carrier = 16'($urandom);
    bit_valid = (tx_q.size() > 0);
    bit_in    = (tx_q.size() > 0) ? tx_q[0] : 1'b0;
    c   = carrier;
    bnd = ((m_n % SPS) == AO);
    acc = rst_n && bit_valid && ((mq.size() == 0) || bnd);
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_n = 0; m_run = 0; m_strb = 0; m_und = 0;
      for (int i = 0; i < 2; i++) begin
        m_sym[i] = 0; m_prev[i] = 0; m_out[i] = '0;
      end
    end else begin
      m_strb = 0;
      if (bnd) begin
        if (mq.size() > 0) begin
          b = mq.pop_front();
          m_sym[0] = b;
          m_sym[1] = m_prev[1] ^ b;
          m_prev[1] = m_sym[1];
          m_run = 1; m_strb = 1;
        end else begin
          if (m_run) m_und = 1;
          m_run = 0;
        end
      end
      if (acc) mq.push_back(bit_in);
      for (int i = 0; i < 2; i++)
        m_out[i] = !m_run ? 16'sd0 : (m_sym[i] ? neg_sat(c) : c);
      m_n++;
    end
    if (acc) void'(tx_q.pop_front());
    #1;
  endtask

  task automatic do_reset(input int unsigned n);
    rst_n = 1'b0;
    tx_q.delete();
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rand_car = 1;
    rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          errors++; $display("FAIL reset_hold dut%0d c=%0d got=%h exp=%h", i, c, obs_vec(i), exp_vec(i));
        end
      end
      checks++;
      if (bus0.bit_ready !== 1'b0) begin
        errors++; $display("FAIL reset_ready got=%b exp=0", bus0.bit_ready);
      end
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          errors++; $display("FAIL idle_run dut%0d c=%0d got=%h exp=%h", i, c, obs_vec(i), exp_vec(i));
        end
      end
    end
    checks++;
    if ({bus0.mod_valid, bus0.underrun, bus0.bit_ready} !== 3'b001) begin
      errors++; $display("FAIL idle_flags got=%b exp=001", {bus0.mod_valid, bus0.underrun, bus0.bit_ready});
    end
  endtask

  task automatic test_single_bit();
    int unsigned n_pos = 0, n_strb = 0, strb_at = 0;
    do_reset(3);
    rand_car = 0;
    carrier = 16'sd1000;
    for (int unsigned c = 1; c <= 700; c++) begin
      if (c == 10) tx_q.push_back(1'b0);
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          errors++; $display("FAIL single_bit dut%0d c=%0d got=%h exp=%h", i, c, obs_vec(i), exp_vec(i));
        end
      end
      if (c == 10) begin
        checks++;
        if (bus0.bit_ready !== 1'b0) begin
          errors++; $display("FAIL ready_after_accept got=%b exp=0", bus0.bit_ready);
        end
      end
      if (bus0.sym_strobe) begin n_strb++; strb_at = c; end
      if (bus0.mod_valid && bus0.mod_sig == 16'sd1000) n_pos++;
    end
    checks++;
    if (n_strb != 1 || strb_at != AO + 1 + SPS) begin
      errors++; $display("FAIL first_strobe got=%0d@%0d exp=1@%0d", n_strb, strb_at, AO + 1 + SPS);
    end
    checks++;
    if (n_pos != SPS) begin
      errors++; $display("FAIL symbol_len got=%0d exp=%0d", n_pos, SPS);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned strb[$];
    int unsigned n_neg = 0;
    logic signed [15:0] c_prev;
    do_reset(2);
    rand_car = 1;
    tx_q = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int unsigned c = 1; c <= 1100; c++) begin
      if (rand_car) carrier = 16'($urandom);
      c_prev = carrier;
      rand_car = 0;
      step();
      rand_car = 1;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          errors++; $display("FAIL back_to_back dut%0d c=%0d got=%h exp=%h", i, c, obs_vec(i), exp_vec(i));
        end
      end
      if (bus0.sym_strobe) strb.push_back(c);
      if ((strb.size() == 2 || strb.size() == 3) && bus0.mod_valid && bus0.mod_sig === neg_sat(c_prev))
        n_neg++;
    end
    checks++;
    if (strb.size() != 4) begin
      errors++; $display("FAIL strobe_count got=%0d exp=4", strb.size());
    end else begin
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (strb[k] - strb[k-1] != SPS) begin
          errors++; $display("FAIL strobe_spacing k=%0d got=%0d exp=%0d", k, strb[k] - strb[k-1], SPS);
        end
      end
    end
    checks++;
    if (n_neg != 2 * SPS) begin
      errors++; $display("FAIL negated_samples got=%0d exp=%0d", n_neg, 2 * SPS);
    end
  endtask

  task automatic test_saturation();
    int unsigned n_max0 = 0, n_min0 = 0, n_max1 = 0;
    do_reset(2);
    rand_car = 0;
    carrier = 16'sh8000;
    tx_q = '{1'b1, 1'b0};
    for (int c = 1; c <= 800; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          errors++; $display("FAIL saturation dut%0d c=%0d got=%h exp=%h", i, c, obs_vec(i), exp_vec(i));
        end
      end
      if (bus0.mod_valid && bus0.mod_sig == 16'sh7FFF) n_max0++;
      if (bus0.mod_valid && bus0.mod_sig == 16'sh8000) n_min0++;
      if (bus1.mod_valid && bus1.mod_sig == 16'sh7FFF) n_max1++;
    end
    checks++;
    if (n_max0 != SPS || n_min0 != SPS) begin
      errors++; $display("FAIL sat_direct got=%0d/%0d exp=%0d/%0d", n_max0, n_min0, SPS, SPS);
    end
    checks++;
    if (n_max1 != 2 * SPS) begin
      errors++; $display("FAIL sat_diff got=%0d exp=%0d", n_max1, 2 * SPS);
    end
  endtask

  task automatic test_underrun();
    int unsigned n_live = 0;
    do_reset(2);
    rand_car = 1;
    tx_q.push_back(1'b1);
    for (int c = 1; c <= 1100; c++) begin
      if (c == 601) tx_q.push_back(1'b0);
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          errors++; $display("FAIL underrun_seq dut%0d c=%0d got=%h exp=%h", i, c, obs_vec(i), exp_vec(i));
        end
      end
      if (c == 600) begin
        checks++;
        if ({bus0.underrun, bus0.mod_valid} !== 2'b10) begin
          errors++; $display("FAIL underrun_set got=%b exp=10", {bus0.underrun, bus0.mod_valid});
        end
      end
      if (c > 600 && bus0.mod_valid && bus0.underrun) n_live++;
    end
    checks++;
    if (n_live != SPS) begin
      errors++; $display("FAIL underrun_sticky got=%0d exp=%0d", n_live, SPS);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if ({bus0.underrun, bus1.underrun} !== 2'b00) begin
      errors++; $display("FAIL underrun_clear got=%b exp=00", {bus0.underrun, bus1.underrun});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_diff();
    logic [3:0] pol0 = '0, pol1 = '0;
    int unsigned n_valid = 0;
    do_reset(2);
    rand_car = 0;
    carrier = 16'sd1000;
    tx_q = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int c = 1; c <= 1100; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          errors++; $display("FAIL diff_seq dut%0d c=%0d got=%h exp=%h", i, c, obs_vec(i), exp_vec(i));
        end
      end
      if (bus0.sym_strobe) pol0 = {pol0[2:0], bus0.mod_sig[15]};
      if (bus1.sym_strobe) pol1 = {pol1[2:0], bus1.mod_sig[15]};
    end
    checks++;
    if (pol1 !== 4'b1001) begin
      errors++; $display("FAIL diff_polarity got=%b exp=1001", pol1);
    end
    checks++;
    if (pol0 !== 4'b1101) begin
      errors++; $display("FAIL direct_polarity got=%b exp=1101", pol0);
    end

    // Reset in the middle of the third symbol with the fourth bit buffered.
    do_reset(2);
    rand_car = 1;
    tx_q = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int unsigned c = 1; c <= AO + 1 + 2 * SPS + SPS / 2; c++) step();
    rst_n = 1'b0;
    step();
    checks++;
    if ({bus0.mod_valid, bus1.mod_valid} !== 2'b00) begin
      errors++; $display("FAIL midsym_reset got=%b exp=00", {bus0.mod_valid, bus1.mod_valid});
    end
    rst_n = 1'b1;
    tx_q.delete();
    for (int c = 1; c <= 600; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          errors++; $display("FAIL post_reset dut%0d c=%0d got=%h exp=%h", i, c, obs_vec(i), exp_vec(i));
        end
      end
      if (c == 1) begin
        checks++;
        if (bus1.bit_ready !== 1'b1) begin
          errors++; $display("FAIL buffer_flushed got=%b exp=1", bus1.bit_ready);
        end
      end
      if (bus0.mod_valid || bus1.mod_valid) n_valid++;
    end
    checks++;
    if (n_valid != 0) begin
      errors++; $display("FAIL no_partial_symbol got=%0d exp=0", n_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_sym[i] = 0; m_prev[i] = 0; m_out[i] = '0;
    end
    test_reset();
    test_single_bit();
    test_back_to_back();
    test_saturation();
    test_underrun();
    test_diff();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
